// File: rtl/up_down_pkg.sv
// Shared types and constants for the up/down count-stream checker.
package up_down_pkg;

    typedef enum logic [1:0] {
        HUNT       = 2'd0,
        ACQ        = 2'd1,
        TRACK_UP   = 2'd2,
        TRACK_DOWN = 2'd3
    } chk_state_t;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/up_down_seq_checker_sat_counter.sv
// Saturating event counter: counts inc pulses, sticks at all-ones.
module sat_counter #(
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    output logic [CW-1:0] q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            q <= '0;
        else if (inc && (q != {CW{1'b1}}))
            q <= q + CW'(1);
    end

endmodule

// File: rtl/up_down_seq_checker.sv
// Monitor for a bouncing 0..MAX..0 count stream: locks on, flags deviations,
// reports peak/trough events and keeps saturating period/error counts.
module up_down_seq_checker
    import up_down_pkg::*;
#(
    parameter  int MAX = 5,
    localparam int W   = $clog2(MAX + 1),
    parameter  int CW  = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          valid,
    input  logic [W-1:0]  cnt_in,
    output logic          locked,
    output logic          dir,
    output logic          err,
    output logic          peak,
    output logic          trough,
    output logic [CW-1:0] periods,
    output logic [CW-1:0] err_cnt
);

    localparam logic [W:0] MAX_V = (W + 1)'(MAX);
    localparam logic [W:0] ZERO  = '0;

    chk_state_t state, state_nxt, cls_state;
    logic [W-1:0] prev, prev_nxt;
    logic [W:0]   s, up_exp, dn_exp;
    logic cls_dir, cls_err;
    logic dir_nxt, locked_nxt, err_nxt, peak_nxt, trough_nxt, period_inc;

    // One extra bit keeps prev+1 at MAX and prev-1 at 0 from aliasing onto legal samples.
    assign s      = {1'b0, cnt_in};
    assign up_exp = {1'b0, prev} + (W + 1)'(1);
    assign dn_exp = {1'b0, prev} - (W + 1)'(1);

    // Classification of a sample with no usable history.
    always_comb begin
        cls_state = ACQ;
        cls_dir   = dir;
        cls_err   = 1'b0;
        if (s > MAX_V) begin
            cls_state = HUNT;
            cls_err   = 1'b1;
        end else if (s == ZERO) begin
            cls_state = TRACK_UP;
            cls_dir   = DIR_UP;
        end else if (s == MAX_V) begin
            cls_state = TRACK_DOWN;
            cls_dir   = DIR_DOWN;
        end
    end

    always_comb begin
        state_nxt  = state;
        prev_nxt   = prev;
        dir_nxt    = dir;
        locked_nxt = locked;
        err_nxt    = 1'b0;
        peak_nxt   = 1'b0;
        trough_nxt = 1'b0;
        period_inc = 1'b0;
        if (valid) begin
            // Mismatch path is the default; matches below override it.
            prev_nxt   = cnt_in;
            state_nxt  = cls_state;
            dir_nxt    = cls_dir;
            err_nxt    = cls_err || (state != HUNT);
            locked_nxt = 1'b0;
            unique case (state)
                HUNT: ;
                ACQ: begin
                    if (s == up_exp) begin
                        state_nxt  = (s == MAX_V) ? TRACK_DOWN : TRACK_UP;
                        dir_nxt    = DIR_UP;
                        locked_nxt = 1'b1;
                        err_nxt    = 1'b0;
                        peak_nxt   = (s == MAX_V);
                    end else if (s == dn_exp) begin
                        state_nxt  = (s == ZERO) ? TRACK_UP : TRACK_DOWN;
                        dir_nxt    = DIR_DOWN;
                        locked_nxt = 1'b1;
                        err_nxt    = 1'b0;
                        trough_nxt = (s == ZERO);
                    end
                end
                TRACK_UP: begin
                    if (s == up_exp) begin
                        locked_nxt = 1'b1;
                        err_nxt    = 1'b0;
                        if (s == MAX_V) begin
                            state_nxt = TRACK_DOWN;
                            dir_nxt   = DIR_DOWN;
                            peak_nxt  = 1'b1;
                        end else begin
                            state_nxt = TRACK_UP;
                            dir_nxt   = DIR_UP;
                        end
                    end
                end
                TRACK_DOWN: begin
                    if (s == dn_exp) begin
                        locked_nxt = 1'b1;
                        err_nxt    = 1'b0;
                        if (s == ZERO) begin
                            state_nxt  = TRACK_UP;
                            dir_nxt    = DIR_UP;
                            trough_nxt = 1'b1;
                            period_inc = locked;
                        end else begin
                            state_nxt = TRACK_DOWN;
                            dir_nxt   = DIR_DOWN;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= HUNT;
            prev   <= '0;
            dir    <= DIR_UP;
            locked <= 1'b0;
            err    <= 1'b0;
            peak   <= 1'b0;
            trough <= 1'b0;
        end else begin
            state  <= state_nxt;
            prev   <= prev_nxt;
            dir    <= dir_nxt;
            locked <= locked_nxt;
            err    <= err_nxt;
            peak   <= peak_nxt;
            trough <= trough_nxt;
        end
    end

    sat_counter #(.CW(CW)) u_periods (
        .clk (clk),
        .rst (rst),
        .inc (period_inc),
        .q   (periods)
    );

    sat_counter #(.CW(CW)) u_err_cnt (
        .clk (clk),
        .rst (rst),
        .inc (err_nxt),
        .q   (err_cnt)
    );

endmodule

// File: tb/tb_up_down_seq_checker.sv
// Randomized bench for up_down_seq_checker against a position-in-sequence model.
module tb_up_down_seq_checker;

    localparam int MAX  = 5;
    localparam int W    = $clog2(MAX + 1);
    localparam int CW   = 8;
    localparam int P    = 2 * MAX;
    localparam int SAT  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          valid = 1'b0;
    logic [W-1:0]  cnt_in = '0;
    logic          locked, dir, err, peak, trough;
    logic [CW-1:0] periods, err_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: mode 0 = no history, 1 = one sample held, 2 = tracking at position pos of the bounce.
    int m_mode, m_h, m_pos, m_periods, m_errcnt;
    bit m_locked, m_dir, m_err, m_peak, m_trough;

    up_down_seq_checker #(.MAX(MAX), .CW(CW)) dut (
        .clk     (clk),
        .rst     (rst),
        .valid   (valid),
        .cnt_in  (cnt_in),
        .locked  (locked),
        .dir     (dir),
        .err     (err),
        .peak    (peak),
        .trough  (trough),
        .periods (periods),
        .err_cnt (err_cnt)
    );

    always #5 clk = ~clk;

    function automatic int seq_val(input int k);
        return (k <= MAX) ? k : P - k;
    endfunction

    function automatic void chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endfunction

    function automatic void model_reset();
        m_mode = 0; m_h = 0; m_pos = 0; m_periods = 0; m_errcnt = 0;
        m_locked = 0; m_dir = 1; m_err = 0; m_peak = 0; m_trough = 0;
    endfunction

    function automatic void model_step(input bit v, input int s);
        bit matched = 0;
        bit e = 0;
        int nxt;
        m_err = 0; m_peak = 0; m_trough = 0;
        if (!v) return;
        if (m_mode == 2) begin
            nxt = (m_pos + 1) % P;
            if (s == seq_val(nxt)) begin
                matched = 1;
                if (s == 0 && m_locked) m_periods = (m_periods < SAT) ? m_periods + 1 : SAT;
                m_pos = nxt;
                m_dir = (m_pos < MAX);
            end
        end else if (m_mode == 1) begin
            if (s == m_h + 1) begin
                matched = 1; m_pos = s; m_dir = 1;
            end else if (s == m_h - 1) begin
                matched = 1; m_pos = (P - s) % P; m_dir = 0;
            end
        end
        if (matched) begin
            m_mode = 2; m_locked = 1;
            m_peak = (s == MAX); m_trough = (s == 0);
        end else begin
            if (m_mode != 0) e = 1;
            m_locked = 0;
            if (s > MAX) begin e = 1; m_mode = 0; end
            else if (s == 0) begin m_mode = 2; m_pos = 0; m_dir = 1; end
            else if (s == MAX) begin m_mode = 2; m_pos = MAX; m_dir = 0; end
            else begin m_mode = 1; m_h = s; end
        end
        m_err = e;
        if (e && m_errcnt < SAT) m_errcnt++;
    endfunction

    always @(negedge clk) begin
        chk("locked",  int'(locked),  int'(m_locked));
        chk("dir",     int'(dir),     int'(m_dir));
        chk("err",     int'(err),     int'(m_err));
        chk("peak",    int'(peak),    int'(m_peak));
        chk("trough",  int'(trough),  int'(m_trough));
        chk("periods", int'(periods), m_periods);
        chk("err_cnt", int'(err_cnt), m_errcnt);
    end

    task automatic step(input bit v, input int s);
        @(negedge clk);
        valid  = v;
        cnt_in = W'(s);
        @(posedge clk);
        model_step(v, s);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst = 1'b0;
        model_reset();
        valid = 1'b0;
        #1;
        chk("rst_locked",  int'(locked),  0);
        chk("rst_dir",     int'(dir),     1);
        chk("rst_pulses",  int'({err, peak, trough}), 0);
        chk("rst_periods", int'(periods), 0);
        chk("rst_err_cnt", int'(err_cnt), 0);
        @(negedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        int g, r, v;
        model_reset();
        do_reset();

        // Single clean period from reset.
        for (int k = 0; k <= P; k++) begin
            step(1, seq_val(k % P));
            if (k == 1) chk("lit_lock_after_0", int'(locked), 1);
            if (k == MAX) begin
                chk("lit_peak", int'(peak), 1);
                chk("lit_dir_at_peak", int'(dir), 0);
            end
        end
        chk("lit_trough", int'(trough), 1);
        chk("lit_periods_1", int'(periods), 1);

        // Three more periods.
        for (int k = 1; k <= 3 * P; k++) step(1, seq_val(k % P));
        chk("lit_periods_4", int'(periods), 4);
        chk("lit_no_err", int'(err_cnt), 0);

        // Mid-stream acquisition going down.
        do_reset();
        step(1, 3);
        step(1, 2);
        chk("lit_acq_dir", int'(dir), 0);
        chk("lit_acq_locked", int'(locked), 1);
        step(1, 1);
        step(1, 0);
        chk("lit_acq_trough", int'(trough), 1);
        chk("lit_acq_periods", int'(periods), 1);

        // Stall, recovery, then an out-of-range sample.
        do_reset();
        step(1, 0); step(1, 1); step(1, 2);
        step(1, 2);
        chk("lit_stall_err", int'(err), 1);
        chk("lit_stall_locked", int'(locked), 0);
        chk("lit_stall_errcnt", int'(err_cnt), 1);
        step(1, 3);
        chk("lit_relock", int'(locked), 1);
        chk("lit_relock_dir", int'(dir), 1);
        step(1, 7);
        chk("lit_oor_err", int'(err), 1);
        chk("lit_oor_errcnt", int'(err_cnt), 2);

        // Wrap attempts.
        step(1, 0); step(1, 7);
        step(1, 4); step(1, 5); step(1, 6);

        // Valid gaps.
        for (int k = 0; k < 8; k++) begin
            step(1, seq_val(k));
            for (int j = 0; j < 4; j++) step(0, $urandom_range(0, (1 << W) - 1));
        end

        // Asynchronous reset mid-period.
        step(1, 3);
        do_reset();

        // Randomized stream with perturbations.
        g = 0;
        for (int n = 0; n < 800; n++) begin
            r = $urandom_range(0, 99);
            if (r < 15) step(0, $urandom_range(0, (1 << W) - 1));
            else if (r < 23) step(1, $urandom_range(0, (1 << W) - 1));
            else if (r < 28) step(1, seq_val(g));
            else begin
                if (r < 31) g = $urandom_range(0, P - 1);
                else g = (g + 1) % P;
                v = seq_val(g);
                step(1, v);
            end
        end

        // Error counter saturation.
        do_reset();
        for (int n = 0; n < 260; n++) step(1, 7);
        chk("lit_err_sat", int'(err_cnt), SAT);

        step(0, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
